// File: rtl/timer_sequencer.sv
// timer_sequencer: command-driven prescaled modulo interval timer with one-shot/periodic expiry.
module timer_sequencer #(
  parameter int PRESCALE = 10,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] period,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             tick,
  output logic             expired,
  output logic             cmd_err
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);
  state_t           state_q;
  logic [PW-1:0]    pre_q;
  logic [WIDTH-1:0] count_q, period_q;
  logic             periodic_q, ready_q, err_q;
  logic             acc, term, done_now, illegal;
  assign acc      = cmd_valid && ready_q;
  assign tick     = state_q == RUN && pre_q == PS_MAX;
  assign term     = tick && count_q == period_q - WIDTH'(1);
  assign done_now = term && !periodic_q;
  // a PAUSE landing on a one-shot expiry loses to DONE and counts as illegal
  always_comb begin
    illegal = cmd_op == 2'b00 ? period == '0 :
              cmd_op == 2'b10 ? (state_q != RUN || done_now) :
              cmd_op == 2'b11 ? state_q != PAUSED : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      count_q    <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      ready_q <= !acc;
      err_q   <= acc && illegal;
      if (state_q == RUN) pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        count_q <= term ? '0 : count_q + 1'b1;
        if (done_now) state_q <= DONE;
      end
      // accepted legal commands override the tick's update
      if (acc && !illegal) begin
        if (cmd_op == 2'b00) begin
          period_q   <= period;
          periodic_q <= periodic;
          count_q    <= '0;
          pre_q      <= '0;
          state_q    <= RUN;
        end else if (cmd_op == 2'b01) begin
          count_q <= '0;
          pre_q   <= '0;
          state_q <= IDLE;
        end else begin
          state_q <= cmd_op == 2'b10 ? PAUSED : RUN;
        end
      end
    end
  end
  assign cmd_ready = ready_q;
  assign count     = count_q;
  assign state     = state_q;
  assign busy      = state_q == RUN || state_q == PAUSED;
  assign expired   = term;
  assign cmd_err   = err_q;
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: directed and random checks of timer_sequencer against a step-count model.
module tb_timer_sequencer;
  localparam int P = 4;
  localparam int W = 8;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, periodic = 0;
  logic [1:0] cmd_op = 0;
  logic [W-1:0] period = 0;
  logic cmd_ready, busy, tick, expired, cmd_err;
  logic [W-1:0] count;
  logic [1:0] state;
  logic c1_valid = 0, c1_periodic = 0;
  logic [1:0] c1_op = 0;
  logic [W-1:0] c1_period = 0;
  logic o1_ready, o1_busy, o1_tick, o1_expired, o1_err;
  logic [W-1:0] o1_count;
  logic [1:0] o1_state;
  int n_tests = 0, n_fail = 0;
  bit armed = 0;
  always #5 clk = ~clk;
  timer_sequencer #(.PRESCALE(P), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .period(period), .periodic(periodic), .count(count), .state(state), .busy(busy),
    .tick(tick), .expired(expired), .cmd_err(cmd_err));
  timer_sequencer #(.PRESCALE(1), .WIDTH(W)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(c1_valid), .cmd_ready(o1_ready), .cmd_op(c1_op),
    .period(c1_period), .periodic(c1_periodic), .count(o1_count), .state(o1_state), .busy(o1_busy),
    .tick(o1_tick), .expired(o1_expired), .cmd_err(o1_err));
  // model: state plus number of RUN cycles elapsed since the last START
  int m_state = 0, m_steps = 0, m_period = 0;
  bit m_periodic = 0, m_ready = 1, m_err = 0;
  function automatic bit m_tick();
    return m_state == 1 && (m_steps + 1) % P == 0;
  endfunction
  function automatic bit m_exp();
    return m_tick() && ((m_steps + 1) / P) % m_period == 0;
  endfunction
  function automatic int m_count();
    return (m_state == 1 || m_state == 2) ? (m_steps / P) % m_period : 0;
  endfunction
  always @(posedge clk) begin
    bit acc, ill, ex;
    if (reset) begin
      m_state = 0; m_steps = 0; m_period = 0; m_periodic = 0; m_ready = 1; m_err = 0;
    end else begin
      acc = cmd_valid && m_ready;
      ex = m_exp();
      case (cmd_op)
        2'd0: ill = period == 0;
        2'd2: ill = m_state != 1 || (ex && !m_periodic);
        2'd3: ill = m_state != 2;
        default: ill = 0;
      endcase
      m_err = acc && ill;
      m_ready = !acc;
      if (m_state == 1) begin
        m_steps++;
        if (ex && !m_periodic) begin m_state = 3; m_steps = 0; end
      end
      if (acc && !ill) begin
        case (cmd_op)
          2'd0: begin m_state = 1; m_steps = 0; m_period = int'(period); m_periodic = periodic; end
          2'd1: begin m_state = 0; m_steps = 0; end
          2'd2: m_state = 2;
          default: m_state = 1;
        endcase
      end
    end
  end
  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (armed) begin
    chk("m_state", state, m_state);
    chk("m_count", count, m_count());
    chk("m_ready", cmd_ready, m_ready);
    chk("m_busy", busy, m_state == 1 || m_state == 2);
    chk("m_tick", tick, m_tick());
    chk("m_expired", expired, m_exp());
    chk("m_cmd_err", cmd_err, m_err);
  end
  task automatic go(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(logic [1:0] op, int per, bit prd);
    cmd_valid = 1; cmd_op = op; period = W'(per); periodic = prd;
    @(negedge clk);
    cmd_valid = 0;
  endtask
  initial begin
    go(3);
    reset = 0;
    go(5);
    chk("rst_state", state, 0); chk("rst_count", count, 0); chk("rst_ready", cmd_ready, 1);
    chk("rst_tick", tick, 0); chk("rst_expired", expired, 0); chk("rst_busy", busy, 0);
    chk("rst_err", cmd_err, 0);
    // PRESCALE=1 periodic period=2
    c1_valid = 1; c1_op = 0; c1_period = 2; c1_periodic = 1;
    @(negedge clk);
    c1_valid = 0;
    chk("p1_tick", o1_tick, 1); chk("p1_count1", o1_count, 0);
    go(1); chk("p1_cnt2", o1_count, 1); chk("p1_exp2", o1_expired, 1);
    go(1); chk("p1_cnt3", o1_count, 0); chk("p1_exp3", o1_expired, 0);
    go(1); chk("p1_cnt4", o1_count, 1); chk("p1_exp4", o1_expired, 1);
    go(2); chk("p1_exp6", o1_expired, 1); chk("p1_state", o1_state, 1);
    armed = 1;
    // one-shot period=3 at T
    send(0, 3, 0);
    chk("os_run", state, 1);
    go(3); chk("os_tick1", tick, 1); chk("os_cnt_t1", count, 0);
    go(1); chk("os_cnt1", count, 1);
    go(7); chk("os_expired", expired, 1); chk("os_cnt_last", count, 2);
    go(1); chk("os_done", state, 3); chk("os_cnt0", count, 0); chk("os_busy", busy, 0);
    // pause/resume, period=5
    send(0, 5, 0);
    go(5);
    send(2, 0, 0);
    chk("pz_state", state, 2); chk("pz_cnt", count, 1);
    go(9); chk("pz_cnt_hold", count, 1); chk("pz_state_hold", state, 2);
    send(3, 0, 0);
    go(12); chk("pz_noexp29", expired, 0);
    go(1); chk("pz_exp30", expired, 1);
    // STOP coincident with one-shot expiry, then illegal commands
    send(1, 0, 0);
    chk("stop_idle", state, 0);
    go(1);
    send(3, 0, 0);
    chk("ill_resume_err", cmd_err, 1); chk("ill_resume_state", state, 0);
    go(1); chk("ill_err_clear", cmd_err, 0);
    send(0, 1, 0);
    go(4); chk("p1_done", state, 3);
    send(2, 0, 0);
    chk("ill_pause_err", cmd_err, 1); chk("ill_pause_state", state, 3);
    go(1);
    send(0, 0, 1);
    chk("ill_start0_err", cmd_err, 1); chk("ill_start0_state", state, 3);
    go(1);
    // STOP on a periodic terminal tick
    send(0, 2, 1);
    go(7); chk("st_exp", expired, 1);
    send(1, 0, 0);
    chk("st_state", state, 0); chk("st_count", count, 0); chk("st_ready", cmd_ready, 0);
    go(1); chk("st_ready_back", cmd_ready, 1);
    // reset during RUN with a command presented
    send(0, 5, 0);
    go(6);
    cmd_valid = 1; cmd_op = 0; period = 3; reset = 1;
    @(negedge clk);
    reset = 0; cmd_valid = 0;
    chk("rr_state", state, 0); chk("rr_count", count, 0); chk("rr_ready", cmd_ready, 1);
    go(1); chk("rr_err", cmd_err, 0);
    // random phase
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      cmd_valid = $urandom_range(0, 3) == 0;
      cmd_op = 2'($urandom_range(0, 3));
      period = $urandom_range(0, 9) == 0 ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 4));
      periodic = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reset = 0; cmd_valid = 0;
    go(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Command-driven controller that sequences a prescaled modulo counter for interval timing. It accepts START/STOP/PAUSE/RESUME commands over a valid/ready handshake and runs a count of 0..period-1. It generates the prescaler tick, which also serves as the enable strobe for downstream counters, and reports expiry in one-shot or periodic mode. It sits between a control FSM or register block and the mod-counter datapath that it enables.

## Interface
- PRESCALE, 10: clk cycles per count step; legal range 1 or more.
- WIDTH, 8: width of period and count.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_op  in  2  command: 00 START, 01 STOP, 10 PAUSE, 11 RESUME.
- period  in  WIDTH  terminal count for START; sampled only when START is accepted.
- periodic  in  1  mode for START: 1 = auto-reload, 0 = one-shot; sampled with period.
- count  out  WIDTH  current count value.
- state  out  2  current state: 0 IDLE, 1 RUN, 2 PAUSED, 3 DONE.
- busy  out  1  high in RUN or PAUSED.
- tick  out  1  prescaler strobe; enable for external counters.
- expired  out  1  one-cycle pulse on the terminal step.
- cmd_err  out  1  one-cycle pulse, cycle after an illegal command was accepted.

## Operation
- A command is accepted when cmd_valid && cmd_ready in the same cycle.
- cmd_ready is registered. It drops for exactly the one cycle after an acceptance, then returns high. Maximum rate is one command per 2 cycles.
- START, legal in any state:
  - period_reg <= period; periodic_reg <= periodic; count <= 0; prescaler <= 0; state -> RUN.
  - START in RUN restarts the timer.
  - START with period == 0 is illegal: cmd_err, no state change.
- STOP, legal in any state: state -> IDLE, count <= 0, prescaler <= 0.
- PAUSE: legal only in RUN; state -> PAUSED, count and prescaler frozen.
- RESUME: legal only in PAUSED; state -> RUN, counting continues from the frozen values.
- Illegal commands are accepted (the handshake completes) and ignored; cmd_err pulses.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - tick = (state==RUN) && (prescaler==PRESCALE-1), decoded from registers only.
  - On tick: if count == period_reg-1, then expired = 1 and count <= 0, and state stays RUN if periodic_reg, else goes to DONE. Otherwise count <= count+1.
- DONE: count holds 0 and busy = 0. Only START leaves DONE to RUN; STOP leaves to IDLE.
- Simultaneous events:
  - START or STOP coincident with tick: the command wins and the tick's count update is discarded. tick/expired still pulse because they are state-decoded.
  - PAUSE coincident with a non-terminal tick: the count update completes, then PAUSED.
  - PAUSE coincident with a terminal one-shot expiry: DONE wins; PAUSE is treated as illegal and cmd_err pulses.
- Prescaler width is max(1, $clog2(PRESCALE)). With PRESCALE = 1, tick is high on every RUN cycle.
- Count arithmetic is WIDTH-bit unsigned. The largest usable period is 2^WIDTH-1, giving count range 0..period-1.

## Timing
- Reset values: state IDLE, count 0, prescaler 0, period_reg 0, periodic_reg 0, cmd_ready 1, busy 0, tick 0, expired 0, cmd_err 0.
- Reset asserted mid-operation returns every register to its reset value on the next edge. A command presented in that cycle is dropped.
- START accepted in cycle T:
  - state = RUN from T+1.
  - Ticks occur in cycles T+k*PRESCALE, k = 1, 2, ...
  - count = k after tick k.
  - expired occurs in cycle T + period*PRESCALE.
- Periodic mode: the next expiry follows every period*PRESCALE cycles with no gap.
- A PAUSE/RESUME pair adds exactly the number of cycles spent in PAUSED to the expiry time.
- cmd_err asserts in cycle T+1 for a command accepted in cycle T.

## Test plan
- Reset, then idle 5 cycles -> state 0, count 0, cmd_ready 1; tick, expired, busy all 0.
- PRESCALE=4, START period=3, periodic=0 accepted at cycle 10 -> ticks at 14, 18, 22; expired at 22; state DONE from 23; count 0.
- periodic=1, period=2, PRESCALE=1, START at cycle 0 -> expired at 2, 4, 6…; count sequence 1, 0, 1, 0.
- PRESCALE=4, period=5: PAUSE at cycle 6 after START at cycle 0, RESUME at cycle 16 -> count frozen at 1 while PAUSED; expired at cycle 30, shifted by the 10-cycle pause.
- RESUME in IDLE, PAUSE in DONE, START with period=0 -> each accepted; cmd_err pulses one cycle later; state unchanged.
- STOP coincident with a terminal tick, and reset asserted during RUN -> state IDLE, count 0 next cycle; no DONE entered; cmd_ready low one cycle after STOP only.
